// File: rtl/bus_pkg.sv
// Shared constants for the bus responder: register map, bit positions, limits.
// Latency: n/a (package).
// Backpressure: n/a (package).
package bus_pkg;

  localparam logic [15:0] PERIPH_BASE_DEF = 16'hFF00;

  // Register offsets from PERIPH_BASE
  localparam logic [2:0] OFF_COUNT    = 3'd0;
  localparam logic [2:0] OFF_CTRL     = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_FAULTCNT = 3'd4;
  localparam int         REG_SPAN     = 5;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_CLR_BIT   = 1;
  localparam int STAT_MATCH_BIT = 0;
  localparam int STAT_FAULT_BIT = 1;

  localparam logic [15:0] FAULTCNT_MAX = 16'hFFFF;

  // Saturating increment used by the fault counter
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == FAULTCNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Free-running timer: COUNT/CTRL/COMPARE registers plus match-event generation.
// Latency: register writes take effect on the next edge; o_match_evt is combinational.
// Backpressure: none; write enables are always accepted.
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_wdata                   write data shared by all three registers
//   i_we_count/ctrl/compare   per-register write enables from the responder decode
//   o_count, o_ctrl, o_compare register contents for read-back
//   o_match_evt               timer enabled and COUNT == COMPARE this cycle
module bus_timer
  import bus_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_wdata,
  input  logic        i_we_count,
  input  logic        i_we_ctrl,
  input  logic        i_we_compare,
  output logic [15:0] o_count,
  output logic [1:0]  o_ctrl,
  output logic [15:0] o_compare,
  output logic        o_match_evt
);

  logic [15:0] r_count;
  logic [15:0] r_compare;
  logic [1:0]  r_ctrl;
  logic        w_en;
  logic        w_clr;
  logic        w_hit;

  assign w_en  = r_ctrl[CTRL_EN_BIT];
  assign w_clr = r_ctrl[CTRL_CLR_BIT];
  assign w_hit = w_en && (r_count == r_compare);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count   <= '0;
      r_compare <= '0;
      r_ctrl    <= '0;
    end else begin
      // An initiator write to COUNT overrides the increment for that cycle
      if (i_we_count) begin
        r_count <= i_wdata;
      end else if (w_en) begin
        r_count <= (w_hit && w_clr) ? 16'd0 : r_count + 16'd1;
      end
      if (i_we_ctrl) begin
        r_ctrl <= {i_wdata[CTRL_CLR_BIT], i_wdata[CTRL_EN_BIT]};
      end
      if (i_we_compare) begin
        r_compare <= i_wdata;
      end
    end
  end

  assign o_count     = r_count;
  assign o_ctrl      = r_ctrl;
  assign o_compare   = r_compare;
  assign o_match_evt = w_hit;

endmodule

// File: rtl/bus_responder.sv
// Bus target: word RAM, timer and status registers with unmapped-write fault tracking.
// Latency: reads are combinational (same cycle); writes land on the next rising edge.
// Backpressure: none; every access completes in its cycle, load port beats initiator RAM writes.
//
// Ports:
//   aClock, aReset                        clock, async active-low reset
//   anAddress, aData, aWrite, anOutData   initiator word bus
//   aLoadWrite, aLoadAddress, aLoadData   program-load port (RAM only)
//   anOutMatch, anOutFault                registered STATUS.match / STATUS.fault
module bus_responder
  import bus_pkg::*;
#(
  parameter int          RAM_WORDS   = 2048,
  parameter logic [15:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
  input  logic        aClock,
  input  logic        aReset,
  input  logic [15:0] anAddress,
  input  logic [15:0] aData,
  input  logic        aWrite,
  output logic [15:0] anOutData,
  input  logic        aLoadWrite,
  input  logic [15:0] aLoadAddress,
  input  logic [15:0] aLoadData,
  output logic        anOutMatch,
  output logic        anOutFault
);

  localparam int          AW      = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [16:0] RAM_LIM = 17'(RAM_WORDS);
  localparam logic [16:0] REG_LO  = {1'b0, PERIPH_BASE};
  localparam logic [16:0] REG_HI  = REG_LO + 17'(REG_SPAN);

  logic [15:0]   r_ram [RAM_WORDS];
  logic [1:0]    r_status;
  logic [15:0]   r_faultcnt;

  logic          w_is_ram;
  logic          w_is_reg;
  logic [2:0]    w_off;
  logic          w_load_ok;
  logic          w_ram_we;
  logic          w_reg_we;
  logic          w_fault_evt;
  logic          w_clr_match;
  logic          w_clr_fault;
  logic [AW-1:0] w_ram_idx;
  logic [AW-1:0] w_load_idx;
  logic [15:0]   w_count;
  logic [15:0]   w_compare;
  logic [1:0]    w_ctrl;
  logic          w_match_evt;
  logic [15:0]   w_rdata;

  // Address decode (17-bit compares so a register block near 0xFFFF cannot wrap)
  assign w_is_ram   = ({1'b0, anAddress} < RAM_LIM);
  assign w_is_reg   = !w_is_ram && ({1'b0, anAddress} >= REG_LO) && ({1'b0, anAddress} < REG_HI);
  assign w_off      = 3'(anAddress - PERIPH_BASE);
  assign w_ram_idx  = anAddress[AW-1:0];
  assign w_load_idx = aLoadAddress[AW-1:0];

  // Load port owns the RAM write port for the cycle, so a concurrent initiator
  // RAM write is simply dropped.
  assign w_load_ok   = aLoadWrite && ({1'b0, aLoadAddress} < RAM_LIM);
  assign w_ram_we    = aWrite && w_is_ram && !w_load_ok;
  assign w_reg_we    = aWrite && w_is_reg;
  assign w_fault_evt = aWrite && !w_is_ram && !w_is_reg;
  assign w_clr_match = w_reg_we && (w_off == OFF_STATUS) && aData[STAT_MATCH_BIT];
  assign w_clr_fault = w_reg_we && (w_off == OFF_STATUS) && aData[STAT_FAULT_BIT];

  bus_timer u_timer (
    .i_clk        (aClock),
    .i_rst_n      (aReset),
    .i_wdata      (aData),
    .i_we_count   (w_reg_we && (w_off == OFF_COUNT)),
    .i_we_ctrl    (w_reg_we && (w_off == OFF_CTRL)),
    .i_we_compare (w_reg_we && (w_off == OFF_COMPARE)),
    .o_count      (w_count),
    .o_ctrl       (w_ctrl),
    .o_compare    (w_compare),
    .o_match_evt  (w_match_evt)
  );

  // RAM contents survive reset; the reset branch only suppresses writes so a
  // write in flight when reset asserts is lost.
  always_ff @(posedge aClock or negedge aReset) begin
    if (!aReset) begin
    end else if (w_load_ok) begin
      r_ram[w_load_idx] <= aLoadData;
    end else if (w_ram_we) begin
      r_ram[w_ram_idx] <= aData;
    end
  end

  // STATUS bits: set events dominate a simultaneous write-1-to-clear
  always_ff @(posedge aClock or negedge aReset) begin
    if (!aReset) begin
      r_status   <= '0;
      r_faultcnt <= '0;
    end else begin
      r_status[STAT_MATCH_BIT] <= w_match_evt | (r_status[STAT_MATCH_BIT] & ~w_clr_match);
      r_status[STAT_FAULT_BIT] <= w_fault_evt | (r_status[STAT_FAULT_BIT] & ~w_clr_fault);
      if (w_fault_evt) begin
        r_faultcnt <= sat_inc(r_faultcnt);
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_is_ram) begin
      w_rdata = r_ram[w_ram_idx];
    end else if (w_is_reg) begin
      case (w_off)
        OFF_COUNT:    w_rdata = w_count;
        OFF_CTRL:     w_rdata = {14'd0, w_ctrl};
        OFF_COMPARE:  w_rdata = w_compare;
        OFF_STATUS:   w_rdata = {14'd0, r_status};
        OFF_FAULTCNT: w_rdata = r_faultcnt;
        default:      w_rdata = '0;
      endcase
    end
  end

  assign anOutData  = w_rdata;
  assign anOutMatch = r_status[STAT_MATCH_BIT];
  assign anOutFault = r_status[STAT_FAULT_BIT];

endmodule

// File: tb/tb_bus_responder.sv
module tb_bus_responder;

  localparam int          RW = 2048;
  localparam logic [15:0] PB = 16'hFF00;

  logic        aClock = 1'b0;
  logic        aReset = 1'b0;
  logic [15:0] anAddress = '0;
  logic [15:0] aData = '0;
  logic        aWrite = 1'b0;
  logic [15:0] anOutData;
  logic        aLoadWrite = 1'b0;
  logic [15:0] aLoadAddress = '0;
  logic [15:0] aLoadData = '0;
  logic        anOutMatch;
  logic        anOutFault;

  int n_vec = 0;
  int n_err = 0;

  bus_responder #(.RAM_WORDS(RW), .PERIPH_BASE(PB)) dut (
    .aClock       (aClock),
    .aReset       (aReset),
    .anAddress    (anAddress),
    .aData        (aData),
    .aWrite       (aWrite),
    .anOutData    (anOutData),
    .aLoadWrite   (aLoadWrite),
    .aLoadAddress (aLoadAddress),
    .aLoadData    (aLoadData),
    .anOutMatch   (anOutMatch),
    .anOutFault   (anOutFault)
  );

  always #10 aClock = ~aClock;

  // ---------------- reference model (architectural state) ----------------
  logic [15:0] m_ram [RW];
  logic [15:0] m_count, m_cmp, m_fcnt;
  bit          m_en, m_clr, m_match, m_fault;

  function automatic bit is_unmapped(input logic [15:0] a);
    return !(int'(a) < RW) && !(int'(a) >= int'(PB) && int'(a) < int'(PB) + 5);
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    int off;
    if (int'(a) < RW) return m_ram[a[10:0]];
    off = int'(a) - int'(PB);
    case (off)
      0: return m_count;
      1: return {14'd0, m_clr, m_en};
      2: return m_cmp;
      3: return {14'd0, m_fault, m_match};
      4: return m_fcnt;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_count = 0; m_cmp = 0; m_fcnt = 0;
    m_en = 0; m_clr = 0; m_match = 0; m_fault = 0;
  endtask

  // Next architectural state from the current bus inputs at a rising edge
  task automatic model_tick();
    logic [15:0] a, d;
    bit hit, wr_reg, unm;
    int off;
    a = anAddress; d = aData;
    off = int'(a) - int'(PB);
    hit = m_en && (m_count == m_cmp);
    wr_reg = aWrite && !(int'(a) < RW) && off >= 0 && off < 5;
    unm = aWrite && is_unmapped(a);
    if (aLoadWrite && int'(aLoadAddress) < RW) m_ram[aLoadAddress[10:0]] = aLoadData;
    else if (aWrite && int'(a) < RW) m_ram[a[10:0]] = d;
    m_match = hit || (m_match && !(wr_reg && off == 3 && d[0]));
    m_fault = unm || (m_fault && !(wr_reg && off == 3 && d[1]));
    if (unm && m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
    if (wr_reg && off == 0) m_count = d;
    else if (m_en) m_count = (hit && m_clr) ? 16'h0000 : m_count + 16'd1;
    if (wr_reg && off == 1) begin m_en = d[0]; m_clr = d[1]; end
    if (wr_reg && off == 2) m_cmp = d;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit we, input logic [15:0] a, input logic [15:0] d,
                       input bit lw, input logic [15:0] la, input logic [15:0] ld);
    aWrite = we; anAddress = a; aData = d;
    aLoadWrite = lw; aLoadAddress = la; aLoadData = ld;
  endtask

  task automatic tick();
    @(posedge aClock);
    if (aReset) model_tick(); else model_reset();
    #1;
    aWrite = 1'b0; aLoadWrite = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    drive(1'b1, a, d, 1'b0, 16'h0, 16'h0);
    tick();
  endtask

  task automatic peek(input logic [15:0] a, output logic [15:0] d);
    anAddress = a;
    #1;
    d = anOutData;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] v;
    model_reset();
    #3;
    n_vec++;
    if (anOutMatch !== 1'b0 || anOutFault !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: match=%b fault=%b want 0/0", anOutMatch, anOutFault);
    end
    for (int i = 0; i < 5; i++) begin
      peek(PB + 16'(i), v);
      n_vec++;
      if (v !== 16'h0000) begin
        n_err++; $display("FAIL reset_reg%0d: got %h want 0000", i, v);
      end
    end
    @(negedge aClock);
    aReset = 1'b1;
    wr(PB + 16'd2, 16'h0077);
    peek(PB + 16'd2, v);
    n_vec++;
    if (v !== 16'h0077) begin
      n_err++; $display("FAIL first_write: got %h want 0077", v);
    end
  endtask

  task automatic test_load_read();
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0400, 16'hABCD);
    tick();
    anAddress = 16'h0400;
    #1;
    n_vec++;
    if (anOutData !== 16'hABCD) begin
      n_err++; $display("FAIL load_read: got %h want abcd", anOutData);
    end
  endtask

  task automatic test_load_priority();
    logic [15:0] v;
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0300, 16'h1111); tick();
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0301, 16'h2222); tick();
    drive(1'b1, 16'h0300, 16'h1234, 1'b1, 16'h0301, 16'h5678); tick();
    peek(16'h0301, v);
    n_vec++;
    if (v !== 16'h5678) begin n_err++; $display("FAIL load_prio_301: got %h want 5678", v); end
    peek(16'h0300, v);
    n_vec++;
    if (v !== 16'h1111) begin n_err++; $display("FAIL load_prio_300: got %h want 1111", v); end
    n_vec++;
    if (anOutFault !== 1'b0) begin n_err++; $display("FAIL load_prio_fault: got %b want 0", anOutFault); end
    // Out-of-range load is ignored and is not a fault
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h9000, 16'hDEAD); tick();
    n_vec++;
    if (anOutFault !== 1'b0) begin n_err++; $display("FAIL load_oor_fault: got %b want 0", anOutFault); end
  endtask

  task automatic test_same_cycle();
    logic [15:0] v;
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0200, 16'h1111); tick();
    drive(1'b1, 16'h0200, 16'h2222, 1'b0, 16'h0, 16'h0);
    #1;
    n_vec++;
    if (anOutData !== 16'h1111) begin n_err++; $display("FAIL rw_same_old: got %h want 1111", anOutData); end
    tick();
    peek(16'h0200, v);
    n_vec++;
    if (v !== 16'h2222) begin n_err++; $display("FAIL rw_same_new: got %h want 2222", v); end
  endtask

  task automatic test_timer();
    logic [15:0] v;
    int wraps;
    wr(PB + 16'd2, 16'd5);
    wr(PB + 16'd0, 16'd0);
    wr(PB + 16'd1, 16'd3);
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      peek(PB, v);
      n_vec++;
      if (v !== m_count || anOutMatch !== m_match) begin
        n_err++; $display("FAIL timer_run%0d: count=%h match=%b want %h/%b", i, v, anOutMatch, m_count, m_match);
      end
      if (v == 16'd5) wraps++;
      tick();
    end
    n_vec++;
    if (wraps < 2) begin n_err++; $display("FAIL timer_wrap: saw 5 %0d times want >=2", wraps); end
    wr(PB + 16'd1, 16'd0);
    n_vec++;
    if (anOutMatch !== 1'b1) begin n_err++; $display("FAIL timer_match_set: got %b want 1", anOutMatch); end
    wr(PB + 16'd3, 16'd1);
    n_vec++;
    if (anOutMatch !== 1'b0) begin n_err++; $display("FAIL timer_w1c: got %b want 0", anOutMatch); end
    // Write to COUNT while running beats the increment
    wr(PB + 16'd2, 16'hFFFF);
    wr(PB + 16'd1, 16'd1);
    tick(); tick();
    wr(PB + 16'd0, 16'h0100);
    peek(PB, v);
    n_vec++;
    if (v !== 16'h0100) begin n_err++; $display("FAIL count_write_wins: got %h want 0100", v); end
    wr(PB + 16'd1, 16'd0);
    tick(); tick(); tick();
    peek(PB, v);
    n_vec++;
    if (v !== m_count || anOutMatch !== 1'b0) begin
      n_err++; $display("FAIL timer_hold: count=%h match=%b want %h/0", v, anOutMatch, m_count);
    end
  endtask

  task automatic test_fault();
    logic [15:0] v;
    for (int i = 0; i < 3; i++) wr(16'h8000, 16'h5A5A);
    peek(PB + 16'd4, v);
    n_vec++;
    if (v !== 16'd3 || anOutFault !== 1'b1) begin
      n_err++; $display("FAIL fault_count: cnt=%h fault=%b want 0003/1", v, anOutFault);
    end
    peek(16'h8000, v);
    n_vec++;
    if (v !== 16'h0000) begin n_err++; $display("FAIL unmapped_read: got %h want 0000", v); end
    tick();
    peek(PB + 16'd4, v);
    n_vec++;
    if (v !== 16'd3) begin n_err++; $display("FAIL fault_read_side: got %h want 0003", v); end
    wr(PB + 16'd3, 16'd2);
    n_vec++;
    if (anOutFault !== 1'b0) begin n_err++; $display("FAIL fault_w1c: got %b want 0", anOutFault); end
    wr(PB + 16'd4, 16'h1234);
    peek(PB + 16'd4, v);
    n_vec++;
    if (v !== 16'd3 || anOutFault !== 1'b0) begin
      n_err++; $display("FAIL faultcnt_ro: cnt=%h fault=%b want 0003/0", v, anOutFault);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, la, exp;
    bit we, lw;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0100 + 16'(i), 16'($urandom));
      tick();
    end
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: a = 16'h0100 + 16'($urandom_range(0, 15));
        1: a = PB + 16'($urandom_range(0, 4));
        2: a = 16'h0800 + 16'($urandom_range(0, 16'hF6FF));
        default: a = PB + 16'd5 + 16'($urandom_range(0, 250));
      endcase
      we = ($urandom_range(0, 1) == 1);
      lw = ($urandom_range(0, 3) == 0);
      la = ($urandom_range(0, 1) == 1) ? 16'h0100 + 16'($urandom_range(0, 15))
                                       : 16'h0800 + 16'($urandom_range(0, 16'h7FFF));
      drive(we, a, 16'($urandom), lw, la, 16'($urandom));
      #1;
      exp = m_read(a);
      n_vec++;
      if (anOutData !== exp) begin
        n_err++; $display("FAIL rand_read%0d: addr=%h got %h want %h", i, a, anOutData, exp);
      end
      tick();
      n_vec++;
      if (anOutMatch !== m_match || anOutFault !== m_fault) begin
        n_err++; $display("FAIL rand_flags%0d: match=%b fault=%b want %b/%b", i, anOutMatch, anOutFault, m_match, m_fault);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    int budget;
    wr(PB + 16'd1, 16'd0);
    wr(PB + 16'd3, 16'd3);
    wr(PB + 16'd2, 16'h0041);
    wr(PB + 16'd0, 16'h0040);
    wr(PB + 16'd1, 16'd1);
    budget = 10;
    while (m_count != 16'h0042 && budget > 0) begin tick(); budget--; end
    peek(PB, v);
    n_vec++;
    if (budget == 0 || v !== 16'h0042 || anOutMatch !== 1'b1) begin
      n_err++; $display("FAIL pre_reset: count=%h match=%b want 0042/1", v, anOutMatch);
    end
    #4;
    aReset = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (anOutMatch !== 1'b0) begin n_err++; $display("FAIL mid_reset_match: got %b want 0", anOutMatch); end
    peek(PB, v);
    n_vec++;
    if (v !== 16'h0000) begin n_err++; $display("FAIL mid_reset_count: got %h want 0000", v); end
    peek(PB + 16'd1, v);
    n_vec++;
    if (v !== 16'h0000) begin n_err++; $display("FAIL mid_reset_ctrl: got %h want 0000", v); end
    // A RAM write held across an edge while reset is low must be lost
    drive(1'b1, 16'h0400, 16'h5555, 1'b0, 16'h0, 16'h0);
    tick();
    @(negedge aClock);
    aReset = 1'b1;
    peek(16'h0400, v);
    n_vec++;
    if (v !== 16'hABCD) begin n_err++; $display("FAIL ram_retained: got %h want abcd", v); end
  endtask

  task automatic test_fault_sat();
    logic [15:0] v;
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 16'h0800 + 16'(i & 16'h3FFF), 16'h0, 1'b0, 16'h0, 16'h0);
      tick();
    end
    peek(PB + 16'd4, v);
    n_vec++;
    if (v !== 16'hFFFF) begin n_err++; $display("FAIL faultcnt_full: got %h want ffff", v); end
    wr(16'hFFF0, 16'h0);
    peek(PB + 16'd4, v);
    n_vec++;
    if (v !== 16'hFFFF || anOutFault !== 1'b1) begin
      n_err++; $display("FAIL faultcnt_sat: cnt=%h fault=%b want ffff/1", v, anOutFault);
    end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_load_priority();
    test_same_cycle();
    test_timer();
    test_fault();
    test_random();
    test_reset_mid();
    test_fault_sat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter RAM_WORDS, default 2048: RAM size in 16-bit words, mapped at 0x0000..RAM_WORDS-1.
REQ-002 Parameter PERIPH_BASE, default 16'hFF00: base address of the peripheral register block.
REQ-003 aClock  in  1: single clock; all state changes on rising edge.
REQ-004 aReset  in  1: asynchronous, active-low reset.
REQ-005 anAddress  in  16: word address from the bus initiator.
REQ-006 aData  in  16: write data from the initiator.
REQ-007 aWrite  in  1: write strobe; one write per cycle while high.
REQ-008 anOutData  out  16: read data for anAddress.
REQ-009 aLoadWrite  in  1: program-load write strobe, RAM only.
REQ-010 aLoadAddress  in  16: program-load word address.
REQ-011 aLoadData  in  16: program-load data.
REQ-012 anOutMatch  out  1: timer match flag (STATUS bit0).
REQ-013 anOutFault  out  1: unmapped-write fault flag (STATUS bit1).

Function
REQ-014 Reads are combinational: anOutData reflects anAddress in the same cycle; the initiator samples it on the next edge.
REQ-015 A write to an address, followed by a read of the same address in the same cycle, returns the old value; the new value is visible after the edge.
REQ-016 Register map, offset from PERIPH_BASE: 0 COUNT (RW), 1 CTRL (RW, bit0 enable, bit1 clear-on-match, other bits read 0), 2 COMPARE (RW), 3 STATUS (bit0 match, bit1 fault; write-1-to-clear), 4 FAULTCNT (read-only).
REQ-017 Unmapped addresses are RAM_WORDS..PERIPH_BASE-1 and PERIPH_BASE+5..0xFFFF; reads there return 16'h0000 with no side effect.
REQ-018 An aWrite to an unmapped address sets STATUS.fault and increments FAULTCNT, saturating at 16'hFFFF.
REQ-019 A write to FAULTCNT is ignored and is not a fault.
REQ-020 Timer enabled, COUNT != COMPARE: COUNT increments by 1 each cycle and wraps 16'hFFFF->0.
REQ-021 Timer enabled, COUNT == COMPARE: STATUS.match is set; COUNT goes to 0 if clear-on-match, else increments.
REQ-022 Timer disabled: COUNT holds and no match is raised.
REQ-023 An initiator write to COUNT in the same cycle as an increment: the written value wins, with no increment that cycle.
REQ-024 A STATUS write-1-clear coinciding with a set event on the same bit: the set wins.
REQ-025 aLoadWrite writes aLoadData to RAM when aLoadAddress < RAM_WORDS; otherwise the load write is ignored, with no fault.
REQ-026 aLoadWrite and an aWrite to RAM in the same cycle: the load port wins; the initiator's RAM write is dropped (even at a different address) and no fault is raised.
REQ-027 anOutMatch equals STATUS.match and anOutFault equals STATUS.fault, both driven from registers.

Reset
REQ-028 Asserting aReset clears, asynchronously: COUNT, CTRL, COMPARE, STATUS and FAULTCNT to 0; anOutMatch 0; anOutFault 0.
REQ-029 RAM contents are not reset.
REQ-030 anOutData during reset follows REQ-014 (combinational read of RAM and the cleared registers).
REQ-031 Reset asserted mid-write: that write is lost.
REQ-032 The first write is accepted on the first rising edge after reset deassertion.

Structure
REQ-033 Shared package bus_pkg holds: PERIPH_BASE default, register offsets, CTRL and STATUS bit positions, and the FAULTCNT saturation constant.
REQ-034 A single sub-module, bus_timer, implements COUNT/CTRL/COMPARE and match generation, with write-enable inputs from the responder decode.
REQ-035 The responder owns address decode, the RAM array, STATUS and FAULTCNT.

Verification
REQ-036 Load 0x0400 <= 0xABCD via the load port, then read 0x0400 -> anOutData = 0xABCD in the same cycle.
REQ-037 Initiator write 0x0300 <= 0x1234 together with a load write to 0x0301 -> 0x0301 updated, 0x0300 unchanged, anOutFault = 0.
REQ-038 COMPARE = 5, CTRL = 3 -> COUNT runs 0..5 then returns to 0; anOutMatch = 1 from the edge after COUNT = 5; a STATUS write of 1 clears it.
REQ-039 Write 0x8000 three times -> FAULTCNT = 3, anOutFault = 1; a read of 0x8000 returns 0x0000 and FAULTCNT stays 3.
REQ-040 Preload FAULTCNT to 0xFFFF, then apply one more unmapped write -> FAULTCNT stays 0xFFFF.
REQ-041 With the timer running at COUNT = 0x0042, assert aReset mid-cycle -> COUNT, CTRL and anOutMatch go to 0 immediately; RAM at 0x0400 is retained.
